// File: rtl/decode_regfile.sv
`timescale 1ns/1ps
// Decode-stage register file: NUM_RD combinational read ports with write-through
// bypass, one write-back port, a pending-write scoreboard and a reset-time init sweep.
module decode_regfile #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 4,
  parameter int NUM_RD    = 3,
  parameter int PC_IDX    = 15,
  parameter int INIT_MODE = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_W-1:0]          pc_in,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_hazard,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       issue_en,
  input  logic [ADDR_W-1:0]          issue_addr,
  input  logic                       flush,
  output logic                       init_busy
);

  localparam int NREGS = 2**ADDR_W;
  localparam logic PC_EN = (PC_IDX < NREGS);
  localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(PC_IDX);

  logic [DATA_W-1:0] mem [NREGS];
  logic [ADDR_W:0]   init_cnt_q, init_cnt_d;
  logic              init_busy_q, init_busy_d;
  logic [NREGS-1:0]  busy_q, busy_d;
  logic [DATA_W-1:0] init_val;

  assign init_val  = (INIT_MODE == 1) ? DATA_W'(init_cnt_q[ADDR_W-1:0]) : '0;
  assign init_busy = init_busy_q;

  always_comb begin
    init_cnt_d  = init_cnt_q;
    init_busy_d = init_busy_q;
    if (init_busy_q) begin
      init_cnt_d = init_cnt_q + (ADDR_W+1)'(1);
      if (&init_cnt_q[ADDR_W-1:0]) init_busy_d = 1'b0;
    end
  end

  // Scoreboard: flush dominates; otherwise the issue set wins over a same-address write clear.
  always_comb begin
    busy_d = busy_q;
    if (!init_busy_q) begin
      if (flush) begin
        busy_d = '0;
      end else begin
        if (wr_en)    busy_d[wr_addr]    = 1'b0;
        if (issue_en) busy_d[issue_addr] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_cnt_q  <= '0;
      init_busy_q <= 1'b1;
      busy_q      <= '0;
    end else begin
      init_cnt_q  <= init_cnt_d;
      init_busy_q <= init_busy_d;
      busy_q      <= busy_d;
    end
  end

  // Storage is deliberately unreset; the sweep initialises it one entry per cycle.
  always_ff @(posedge clk) begin
    if (init_busy_q) begin
      mem[init_cnt_q[ADDR_W-1:0]] <= init_val;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic              pc_hit;
      logic              wr_hit;

      assign addr   = rd_addr[gi*ADDR_W +: ADDR_W];
      assign pc_hit = PC_EN && (addr == PC_ADDR);
      assign wr_hit = wr_en && (wr_addr == addr);

      assign rd_data[gi*DATA_W +: DATA_W] = init_busy_q ? '0      :
                                            pc_hit      ? pc_in   :
                                            wr_hit      ? wr_data :
                                                          mem[addr];
      assign rd_hazard[gi] = busy_q[addr] & ~wr_hit & ~pc_hit & ~init_busy_q;
    end
  endgenerate

endmodule

// File: tb/tb_decode_regfile.sv
`timescale 1ns/1ps
// Bench for decode_regfile: directed scenarios plus randomized traffic compared
// against an array-based reference model of the register file and scoreboard.
module tb_decode_regfile;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int NR = 3;
  localparam int NREGS = 16;
  localparam int PCI = 15;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [DW-1:0]    pc_in = '0;
  logic [NR*AW-1:0] rd_addr = '0;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_hazard;
  logic             wr_en = 1'b0;
  logic [AW-1:0]    wr_addr = '0;
  logic [DW-1:0]    wr_data = '0;
  logic             issue_en = 1'b0;
  logic [AW-1:0]    issue_addr = '0;
  logic             flush = 1'b0;
  logic             init_busy;

  int n_checks = 0;
  int n_pass = 0;

  // reference model
  logic [DW-1:0] ref_mem [NREGS];
  bit            ref_busy [NREGS];
  int            ref_sweep_left;

  decode_regfile dut (
    .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_hazard(rd_hazard), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_en(issue_en), .issue_addr(issue_addr), .flush(flush), .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] exp_rd(input int a);
    if (ref_sweep_left > 0) return '0;
    if (a == PCI) return pc_in;
    if (wr_en && int'(wr_addr) == a) return wr_data;
    return ref_mem[a];
  endfunction

  function automatic logic exp_hz(input int a);
    return ref_busy[a] && !(wr_en && int'(wr_addr) == a) && (a != PCI) && (ref_sweep_left == 0);
  endfunction

  task automatic assert_reset();
    rst_n = 1'b0;
    ref_sweep_left = NREGS;
    for (int r = 0; r < NREGS; r++) ref_busy[r] = 0;
  endtask

  // Advance one rising edge, applying the architectural update rules to the model.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      ref_sweep_left = NREGS;
      for (int r = 0; r < NREGS; r++) ref_busy[r] = 0;
    end else if (ref_sweep_left > 0) begin
      ref_mem[NREGS - ref_sweep_left] = DW'(NREGS - ref_sweep_left);
      ref_sweep_left--;
    end else begin
      if (wr_en) ref_mem[wr_addr] = wr_data;
      if (flush) begin
        for (int r = 0; r < NREGS; r++) ref_busy[r] = 0;
      end else begin
        if (wr_en) ref_busy[wr_addr] = 0;
        if (issue_en) ref_busy[issue_addr] = 1;
      end
    end
    #1;
  endtask

  task automatic set_rd(input int p, input int a);
    rd_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic test_reset();
    int n;
    assert_reset();
    pc_in = 32'h100;
    for (int p = 0; p < NR; p++) set_rd(p, p + 3);
    tick();
    #2;
    n_checks++;
    if (init_busy !== 1'b1) $display("FAIL reset_busy: got %b want 1", init_busy); else n_pass++;
    n_checks++;
    if (rd_data !== '0) $display("FAIL reset_rd_data: got %h want 0", rd_data); else n_pass++;
    n_checks++;
    if (rd_hazard !== '0) $display("FAIL reset_hazard: got %b want 0", rd_hazard); else n_pass++;
    rst_n = 1'b1;
    n = 0;
    while (n < 40) begin
      tick();
      n++;
      if (!init_busy) break;
    end
    n_checks++;
    if (n !== 16) $display("FAIL sweep_len: got %0d edges want 16", n); else n_pass++;
    $display("reset: sweep edges=%0d", n);
  endtask

  task automatic test_init_values();
    logic [DW-1:0] want;
    pc_in = 32'h100;
    for (int r = 0; r < NREGS; r++) begin
      set_rd(0, r);
      #2;
      want = (r == 15) ? 32'h100 : DW'(r);
      n_checks++;
      if (rd_data[DW-1:0] !== want)
        $display("FAIL init_r%0d: got %h want %h", r, rd_data[DW-1:0], want);
      else n_pass++;
      $display("init read r%0d = %h", r, rd_data[DW-1:0]);
    end
  endtask

  task automatic test_bypass();
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'hDEADBEEF; set_rd(0, 3);
    #2;
    n_checks++;
    if (rd_data[DW-1:0] !== 32'hDEADBEEF) $display("FAIL bypass_same: got %h want deadbeef", rd_data[DW-1:0]); else n_pass++;
    tick();
    wr_en = 1'b0;
    #2;
    n_checks++;
    if (rd_data[DW-1:0] !== 32'hDEADBEEF) $display("FAIL bypass_next: got %h want deadbeef", rd_data[DW-1:0]); else n_pass++;
    $display("bypass: r3 = %h", rd_data[DW-1:0]);
  endtask

  task automatic test_hazard();
    issue_en = 1'b1; issue_addr = 4'd5;
    tick();
    issue_en = 1'b0; set_rd(1, 5);
    #2;
    n_checks++;
    if (rd_hazard[1] !== 1'b1) $display("FAIL hazard_set: got %b want 1", rd_hazard[1]); else n_pass++;
    tick();
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'd7;
    #2;
    n_checks++;
    if (rd_hazard[1] !== 1'b0) $display("FAIL hazard_wb: got %b want 0", rd_hazard[1]); else n_pass++;
    n_checks++;
    if (rd_data[DW +: DW] !== 32'd7) $display("FAIL hazard_wb_data: got %h want 7", rd_data[DW +: DW]); else n_pass++;
    tick();
    wr_en = 1'b0;
    #2;
    n_checks++;
    if (rd_hazard[1] !== 1'b0) $display("FAIL hazard_after: got %b want 0", rd_hazard[1]); else n_pass++;
    $display("hazard: r5 hazard=%b data=%h", rd_hazard[1], rd_data[DW +: DW]);
  endtask

  task automatic test_same_edge();
    issue_en = 1'b1; issue_addr = 4'd2; wr_en = 1'b1; wr_addr = 4'd2; wr_data = 32'h22;
    tick();
    issue_en = 1'b0; wr_en = 1'b0; set_rd(2, 2);
    #2;
    n_checks++;
    if (rd_hazard[2] !== 1'b1) $display("FAIL same_edge: got %b want 1", rd_hazard[2]); else n_pass++;
    $display("same_edge: r2 hazard=%b", rd_hazard[2]);
    wr_en = 1'b1; wr_data = 32'h23;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic test_flush();
    issue_en = 1'b1; issue_addr = 4'd1;
    tick();
    issue_addr = 4'd4;
    tick();
    issue_addr = 4'd6; flush = 1'b1;
    tick();
    issue_en = 1'b0; flush = 1'b0;
    set_rd(0, 1); set_rd(1, 4); set_rd(2, 6);
    #2;
    n_checks++;
    if (rd_hazard !== 3'b000) $display("FAIL flush: got %b want 000", rd_hazard); else n_pass++;
    $display("flush: hazards=%b", rd_hazard);
  endtask

  task automatic test_reset_mid();
    int n;
    for (int sc = 0; sc < 2; sc++) begin
      set_rd(0, 3);
      if (sc == 0) begin
        assert_reset();
        tick();
        rst_n = 1'b1;
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'h55;
        for (int k = 0; k < 7; k++) tick();
        wr_en = 1'b0;
      end else begin
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'h55;
        tick();
        wr_en = 1'b0;
        #2;
        n_checks++;
        if (rd_data[DW-1:0] !== 32'h55) $display("FAIL pre_reset_r3: got %h want 55", rd_data[DW-1:0]); else n_pass++;
      end
      assert_reset();
      #2;
      n_checks++;
      if (init_busy !== 1'b1) $display("FAIL mid_reset_busy%0d: got %b want 1", sc, init_busy); else n_pass++;
      n_checks++;
      if (rd_data[DW-1:0] !== '0) $display("FAIL mid_reset_rd%0d: got %h want 0", sc, rd_data[DW-1:0]); else n_pass++;
      tick();
      rst_n = 1'b1;
      wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'hAA;
      n = 0;
      while (n < 40) begin
        tick();
        n++;
        if (!init_busy) break;
      end
      wr_en = 1'b0;
      #2;
      n_checks++;
      if (n !== 16) $display("FAIL mid_sweep_len%0d: got %0d want 16", sc, n); else n_pass++;
      n_checks++;
      if (rd_data[DW-1:0] !== 32'd3) $display("FAIL mid_r3_%0d: got %h want 3", sc, rd_data[DW-1:0]); else n_pass++;
      $display("reset_mid sc%0d: edges=%0d r3=%h", sc, n, rd_data[DW-1:0]);
    end
  endtask

  task automatic test_random();
    int a;
    int errs;
    logic [DW-1:0] want;
    for (int c = 0; c < 250; c++) begin
      pc_in      = $urandom;
      wr_en      = ($urandom_range(0, 2) == 0);
      wr_addr    = AW'($urandom_range(0, 15));
      wr_data    = $urandom;
      issue_en   = ($urandom_range(0, 1) == 0);
      issue_addr = AW'($urandom_range(0, 15));
      flush      = ($urandom_range(0, 19) == 0);
      for (int p = 0; p < NR; p++) set_rd(p, (p == 0 && wr_en) ? int'(wr_addr) : int'($urandom_range(0, 15)));
      #2;
      errs = 0;
      n_checks++;
      if (init_busy !== (ref_sweep_left > 0)) begin
        $display("FAIL rand_busy c%0d: got %b want %b", c, init_busy, ref_sweep_left > 0); errs++;
      end else n_pass++;
      for (int p = 0; p < NR; p++) begin
        a = int'(rd_addr[p*AW +: AW]);
        want = exp_rd(a);
        n_checks++;
        if (rd_data[p*DW +: DW] !== want) begin
          $display("FAIL rand_rd c%0d p%0d r%0d: got %h want %h", c, p, a, rd_data[p*DW +: DW], want); errs++;
        end else n_pass++;
        n_checks++;
        if (rd_hazard[p] !== exp_hz(a)) begin
          $display("FAIL rand_hz c%0d p%0d r%0d: got %b want %b", c, p, a, rd_hazard[p], exp_hz(a)); errs++;
        end else n_pass++;
      end
      $display("rand c%0d: wr=%b@%0d iss=%b@%0d fl=%b hz=%b errs=%0d", c, wr_en, wr_addr, issue_en, issue_addr, flush, rd_hazard, errs);
      tick();
    end
    wr_en = 1'b0; issue_en = 1'b0; flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_init_values();
    test_bypass();
    test_hazard();
    test_same_edge();
    test_flush();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/decode_regfile.md
# decode_regfile

Parametrised successor to the decode-stage register file. It provides NUM_RD combinational read ports with write-through bypass and one synchronous write-back port. A pending-write scoreboard raises per-port hazards, and a reset-time initialisation sweep loads every register over NREGS cycles instead of using a wide reset fan-out. It sits in ID between instruction field extraction and the ID/EX register, and feeds operands plus hazard flags to the hazard unit.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 4, register address width; NREGS = 2**ADDR_W
- NUM_RD, 3, number of read ports (≥1)
- PC_IDX, 15, register index whose reads return pc_in; a value ≥ NREGS disables PC substitution
- INIT_MODE, 1, init value written by the sweep: 0 writes zero, 1 writes the register index (zero-extended)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- pc_in  in  DATA_W  current PC, substituted for reads of PC_IDX
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port i is bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, packed like rd_addr
- rd_hazard  out  NUM_RD  port i reads a register with an unresolved pending write
- wr_en  in  1  write-back enable
- wr_addr  in  ADDR_W  write-back destination
- wr_data  in  DATA_W  write-back value
- issue_en  in  1  a decoded instruction with a register destination leaves ID this cycle
- issue_addr  in  ADDR_W  destination of that instruction
- flush  in  1  clear the scoreboard (branch taken)
- init_busy  out  1  initialisation sweep in progress

## Operation
- State:
  - array mem[NREGS]
  - sweep counter init_cnt (ADDR_W+1 bits)
  - init_busy flag
  - scoreboard busy[NREGS]
- Async reset (rst_n=0):
  - init_cnt=0, init_busy=1, busy=all 0
  - mem is not reset
- Init sweep, while init_busy=1:
  - Each rising edge writes mem[init_cnt] with the INIT_MODE value and increments init_cnt.
  - On the edge that writes mem[NREGS-1], init_busy clears.
  - wr_en and issue_en are ignored; flush has no visible effect because busy is already 0.
- Write-back: when wr_en=1 and init_busy=0, the rising edge loads mem[wr_addr]=wr_data. This includes PC_IDX; the write is stored but never visible on reads.
- Read port i, combinational, with priority highest first:
  - init_busy=1 → 0
  - rd_addr==PC_IDX → pc_in
  - wr_en=1 and wr_addr==rd_addr → wr_data (write-through bypass)
  - otherwise → mem[rd_addr]
- Scoreboard, per rising edge with init_busy=0:
  - flush=1: all busy bits cleared; issue_en that cycle is ignored.
  - Otherwise, wr_en clears busy[wr_addr], then issue_en sets busy[issue_addr].
  - Same address in the same cycle: the set wins.
- rd_hazard[i] = busy[rd_addr[i]] & ~(wr_en & wr_addr==rd_addr[i]) & (rd_addr[i]!=PC_IDX) & ~init_busy
- Addresses are full-range. No out-of-range case exists.

## Timing
- Reset values:
  - rd_data=0 and rd_hazard=0 while init_busy=1
  - init_busy=1 from rst_n assertion until NREGS rising edges after deassertion
- Read latency is 0 cycles (combinational from rd_addr, wr_*, pc_in).
- Write latency: visible through the bypass in the same cycle; visible from mem on the cycle after the edge.
- The scoreboard updates on the edge. rd_hazard reflects the new busy state in the following cycle.
- rst_n asserted mid-sweep or mid-operation: the sweep restarts from 0 and the scoreboard clears. mem contents are undefined until the sweep completes.
- wr_en, issue_en and flush are sampled only on rising edges. A single-cycle pulse equals one event.

## Test plan
- Reset then 16 idle cycles (defaults):
  - init_busy is high for exactly 16 edges.
  - Afterwards, reading r0..r14 returns 0..14 and r15 returns pc_in (drive 0x100 → 0x100).
- Write r3=0xDEADBEEF with port0 addr=3 in the same cycle:
  - rd_data0=0xDEADBEEF in that cycle (bypass).
  - The next cycle, with wr_en=0, still shows 0xDEADBEEF.
- Issue r5, then read r5 on port1:
  - rd_hazard[1]=1 from the next cycle.
  - In the cycle with wr_en to r5 and wr_data=7: rd_hazard[1]=0 and rd_data1=7.
  - Afterwards hazard stays 0.
- Same-edge issue_en=1 and wr_en=1, both to r2: busy[2] remains set, so a later read of r2 raises the hazard.
- Issue r1 and r4, then pulse flush together with issue_en for r6: no hazard on r1, r4 or r6 in the next cycle.
- Assert rst_n=0 for 1 cycle after a write of r3=0x55 (at sweep cycle 7 and again after completion):
  - init_busy rises immediately and rd_data reads 0.
  - The sweep completes 16 edges after release with r3=3.
  - Writes attempted during the sweep are not stored.
